// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data (load/store) requesters.
// Data has priority; a bounded run counter guarantees fetch progress.
module mem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned CNT_W  = $clog2(MAX_DATA_RUN + 1);

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] run_cnt;
    mem_cmd_t         mem_cmd_q;
    logic             grant_i_c;
    logic             grant_d_c;
    logic             run_sat_c;
    logic             mem_done_c;

    assign run_sat_c  = (run_cnt == CNT_W'(MAX_DATA_RUN));
    assign mem_done_c = mem_ready && ((state_q == BUSY_I) || (state_q == BUSY_D));

    // Arbitration: data wins unless it has used up its run while fetch waits.
    always_comb begin
        grant_i_c = 1'b0;
        grant_d_c = 1'b0;
        if (state_q == IDLE) begin
            if (d_valid && !(i_valid && run_sat_c)) begin
                grant_d_c = 1'b1;
            end else if (i_valid) begin
                grant_i_c = 1'b1;
            end
        end
    end

    // Readies stay low throughout reset even though the state reads IDLE.
    assign i_ready = grant_i_c & rst_n;
    assign d_ready = grant_d_c & rst_n;

    assign mem_we    = mem_cmd_q.we;
    assign mem_addr  = mem_cmd_q.addr;
    assign mem_wdata = mem_cmd_q.wdata;
    assign mem_wstrb = mem_cmd_q.wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d_c) begin
                    state_d = BUSY_D;
                end else if (grant_i_c) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, response capture and one-cycle response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_cmd_q <= '0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (grant_d_c) begin
                mem_req         <= 1'b1;
                mem_cmd_q.we    <= d_we;
                mem_cmd_q.addr  <= d_addr;
                mem_cmd_q.wdata <= d_wdata;
                mem_cmd_q.wstrb <= d_wstrb;
            end else if (grant_i_c) begin
                mem_req         <= 1'b1;
                mem_cmd_q.we    <= 1'b0;
                mem_cmd_q.addr  <= i_addr;
                mem_cmd_q.wdata <= '0;
                mem_cmd_q.wstrb <= '0;
            end
            if (mem_done_c) begin
                mem_req <= 1'b0;
                if (state_q == BUSY_I) begin
                    i_rdata  <= mem_rdata;
                    i_rvalid <= 1'b1;
                end else begin
                    if (!mem_cmd_q.we) begin
                        d_rdata <= mem_rdata;
                    end
                    d_rvalid <= 1'b1;
                end
            end
        end
    end

    // Consecutive data grants taken while fetch was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (grant_d_c) begin
            if (!i_valid) begin
                run_cnt <= '0;
            end else if (!run_sat_c) begin
                run_cnt <= CNT_W'(run_cnt + 1'b1);
            end
        end else if (grant_i_c) begin
            run_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a wait-state memory responder.
module tb_mem_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            i_valid;
    logic            i_ready;
    logic [XLEN-1:0] i_addr;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;
    logic            d_valid;
    logic            d_ready;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_wstrb;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    int n_checks;
    int n_errors;
    int mem_wait;
    int wcnt;
    bit force_rdy;

    mem_arbiter #(.XLEN(32), .MAX_DATA_RUN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] model_rdata(input logic [XLEN-1:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
    endfunction

    // Memory model: answers mem_ready after mem_wait idle cycles of mem_req.
    always @(negedge clk) begin
        if (force_rdy) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
        end else if (!mem_req) begin
            wcnt      = 0;
            mem_ready = 1'b0;
        end else if (wcnt == mem_wait) begin
            mem_ready = 1'b1;
            mem_rdata = model_rdata(mem_addr);
        end else begin
            mem_ready = 1'b0;
            wcnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    byte   grants[$];
    string exp_order;
    int    rv_seen;

    initial begin
        n_checks = 0; n_errors = 0; mem_wait = 0; wcnt = 0; force_rdy = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        rst_n = 1'b0;
        i_valid = 1'b1; i_addr = 32'h100;
        d_valid = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;

        // Reset state, requests asserted: readies must stay low
        repeat (2) step;
        #1;
        check_eq("rst_i_ready", 32'(i_ready), 32'd0);
        check_eq("rst_d_ready", 32'(d_ready), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        check_eq("rst_i_rdata", i_rdata, 32'd0);
        i_valid = 1'b0; d_valid = 1'b0;
        step;
        rst_n = 1'b1;
        step;

        // Single fetch, zero wait
        i_valid = 1'b1; i_addr = 32'h100;
        #1;
        check_eq("f_i_ready", 32'(i_ready), 32'd1);
        check_eq("f_d_ready", 32'(d_ready), 32'd0);
        step; i_valid = 1'b0; #1;
        check_eq("f_mem_req", 32'(mem_req), 32'd1);
        check_eq("f_mem_addr", mem_addr, 32'h100);
        check_eq("f_mem_we_strb", {27'd0, mem_we, mem_wstrb}, 32'd0);
        check_eq("f_rvalid_early", 32'(i_rvalid), 32'd0);
        step; #1;
        check_eq("f_i_rvalid", 32'(i_rvalid), 32'd1);
        check_eq("f_i_rdata", i_rdata, 32'hDEAD_BEEF);
        check_eq("f_req_drop", 32'(mem_req), 32'd0);
        step; #1;
        check_eq("f_rvalid_once", 32'(i_rvalid), 32'd0);
        check_eq("f_i_rdata_hold", i_rdata, 32'hDEAD_BEEF);

        // Store with 3 wait cycles
        mem_wait = 3;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wstrb = 4'h3;
        #1;
        check_eq("s_d_ready", 32'(d_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step; d_valid = 1'b0; #1;
            check_eq($sformatf("s_req_c%0d", k), 32'(mem_req), 32'd1);
            check_eq($sformatf("s_addr_c%0d", k), mem_addr, 32'h200);
            check_eq($sformatf("s_wdata_c%0d", k), mem_wdata, 32'h1234_5678);
            check_eq($sformatf("s_we_strb_c%0d", k), {27'd0, mem_we, mem_wstrb}, 32'h13);
            check_eq($sformatf("s_rvalid_c%0d", k), 32'(d_rvalid), 32'd0);
        end
        step; #1;
        check_eq("s_d_rvalid", 32'(d_rvalid), 32'd1);
        check_eq("s_d_rdata_kept", d_rdata, 32'd0);
        step; #1;
        check_eq("s_rvalid_once", 32'(d_rvalid), 32'd0);

        // Back-to-back loads at 0x0 and 0x4
        mem_wait = 0;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wstrb = 4'h0;
        #1;
        check_eq("l_ready0", 32'(d_ready), 32'd1);
        step; d_addr = 32'h4; #1;
        check_eq("l_ready_busy0", 32'(d_ready), 32'd0);
        step; #1;
        check_eq("l_ready_resp0", 32'(d_ready), 32'd0);
        check_eq("l_rvalid0", 32'(d_rvalid), 32'd1);
        check_eq("l_rdata0", d_rdata, 32'hA5A5_5A5A);
        step; #1;
        check_eq("l_ready1", 32'(d_ready), 32'd1);
        check_eq("l_rvalid_gap", 32'(d_rvalid), 32'd0);
        step; d_valid = 1'b0; #1;
        check_eq("l_ready_busy1", 32'(d_ready), 32'd0);
        step; #1;
        check_eq("l_rvalid1", 32'(d_rvalid), 32'd1);
        check_eq("l_rdata1", d_rdata, 32'hA5A5_5A5E);
        step;

        // mem_ready while idle must not produce a response
        force_rdy = 1'b1;
        step; step; #1;
        check_eq("idle_rdy_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        check_eq("idle_rdy_rdata", d_rdata, 32'hA5A5_5A5E);
        force_rdy = 1'b0;
        step;

        // Priority and starvation guard: both requesters held continuously
        i_valid = 1'b1; i_addr = 32'h300;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (i_valid && i_ready) grants.push_back(8'h49);
            if (d_valid && d_ready) grants.push_back(8'h44);
            step;
        end
        i_valid = 1'b0; d_valid = 1'b0;
        exp_order = "DDDDIDDDDI";
        check_eq("grant_count", 32'(grants.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("grant_%0d", k),
                     (k < grants.size()) ? 32'(grants[k]) : 32'd0, 32'(exp_order[k]));
        end
        repeat (3) step;

        // Reset in the middle of a waiting load
        mem_wait = 5;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        step; d_valid = 1'b0; #1;
        check_eq("r_mid_req", 32'(mem_req), 32'd1);
        step; #2;
        rst_n = 1'b0;
        #1;
        check_eq("r_req_async", 32'(mem_req), 32'd0);
        check_eq("r_addr_async", mem_addr, 32'd0);
        check_eq("r_d_rdata", d_rdata, 32'd0);
        check_eq("r_i_rdata", i_rdata, 32'd0);
        step;
        rst_n = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            step; #1;
            if (d_rvalid || mem_req) rv_seen++;
        end
        check_eq("r_no_resp", 32'(rv_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
